// File: rtl/apb_mem_bridge_pkg.sv
// apb_mem_bridge_pkg: shared FSM encoding and timeout-counter width helper for the APB bridge
package apb_mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counter must hold the value TIMEOUT itself; a disabled timeout still needs one bit.
    function automatic int cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_mem_bridge.sv
// apb_mem_bridge: PicoRV32 native memory port to single-master APB3 transfer stream
//   PCLK/PRESETn        clock, async active-low reset
//   mem_valid/addr/wdata/wstrb -> mem_ready/rdata   CPU side, one request at a time
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB -> PRDATA/PREADY/PSLVERR   APB3 master side
//   err_flag/err_timeout/err_addr, err_clr   sticky record of the last failed transfer
module apb_mem_bridge
    import apb_mem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              mem_valid,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [31:0]       PWDATA,
    output logic [3:0]        PSTRB,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              err_flag,
    output logic              err_timeout,
    output logic [ADDR_W-1:0] err_addr,
    input  logic              err_clr
);

    localparam int CW = cnt_w(TIMEOUT);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          xfer_ok, xfer_tmo, err_set;
    logic          unused_addr;

    // Only the word address inside the APB window is forwarded.
    assign unused_addr = ^{mem_addr[31:ADDR_W], mem_addr[1:0]};

    always_comb begin
        state_n  = state;
        xfer_ok  = 1'b0;
        xfer_tmo = 1'b0;
        case (state)
            IDLE:   state_n = mem_valid ? SETUP : IDLE;
            SETUP:  state_n = ACCESS;
            ACCESS: begin
                xfer_ok  = PREADY;
                // cnt already holds TIMEOUT stalled cycles, so this stall aborts the transfer
                xfer_tmo = !PREADY && (TIMEOUT != 0) && (cnt == CNT_LIMIT);
                state_n  = (xfer_ok || xfer_tmo) ? DONE : ACCESS;
            end
            DONE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign err_set = (xfer_ok && PSLVERR) || xfer_tmo;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_n;
    end

    // Handshake outputs are registered from the next state so nothing reaches
    // mem_ready combinationally from the APB inputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            mem_ready   <= 1'b0;
            mem_rdata   <= '0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            cnt         <= '0;
            err_flag    <= 1'b0;
            err_timeout <= 1'b0;
            err_addr    <= '0;
        end else begin
            PSEL      <= (state_n == SETUP) || (state_n == ACCESS);
            PENABLE   <= (state_n == ACCESS);
            mem_ready <= (state_n == DONE);
            if (state == IDLE && mem_valid) begin
                PADDR  <= {mem_addr[ADDR_W-1:2], 2'b00};
                PWRITE <= |mem_wstrb;
                PSTRB  <= mem_wstrb;
                PWDATA <= (|mem_wstrb) ? mem_wdata : '0;
            end
            if (state == SETUP)
                cnt <= '0;
            else if (state == ACCESS && !PREADY && cnt != '1)
                cnt <= cnt + 1'b1;
            if (xfer_ok)
                mem_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
            else if (xfer_tmo)
                mem_rdata <= '0;
            // A new error takes priority over a simultaneous clear.
            if (err_set) begin
                err_flag    <= 1'b1;
                err_timeout <= xfer_tmo;
                err_addr    <= PADDR;
            end else if (err_clr) begin
                err_flag    <= 1'b0;
                err_timeout <= 1'b0;
                err_addr    <= '0;
            end
        end
    end

endmodule
